conv_win_cntrl: RTL and testbench
=================================

Name: conv_win_cntrl

Overview:
- Parametrised successor to the single-configuration 5x5 convolution line-buffer controller.
- Accepts a raster pixel stream (AXI-stream style: tuser=SOF, tlast=EOL) and holds K-1 previous lines in circular line-buffer banks.
- Emits one K-tall pixel column per accepted pixel to the kernel window datapath.
- Supports full ready/valid back-pressure, selectable top-border fill (zero or replicate), and line-overflow detection.

Parameters:
- K, 5, kernel height in rows; odd, 3..9; K-1 line-buffer banks.
- PIXEL_W, 8, pixel width in bits.
- MAX_W, 64, maximum line length in pixels (depth of each bank).
- BORDER_MODE, 0, top-border fill: 0 = zero fill, 1 = replicate oldest valid row.

Ports:
- clk  in  1  clock.
- arst_n  in  1  asynchronous active-low reset.
- s_tvalid_i  in  1  input pixel valid.
- s_tdata_i  in  PIXEL_W  input pixel.
- s_tuser_i  in  1  SOF, first pixel of a frame.
- s_tlast_i  in  1  EOL, last pixel of a line.
- s_tready_o  out  1  input ready.
- m_tvalid_o  out  1  output column valid.
- m_tready_i  in  1  downstream ready.
- m_tdata_o  out  K*PIXEL_W  column; lane j = bits [j*PIXEL_W +: PIXEL_W]; lane 0 = oldest row (r-K+1), lane K-1 = current row r.
- m_tuser_o  out  1  SOF aligned to column.
- m_tlast_o  out  1  EOL aligned to column.
- m_row_vld_o  out  K  bit j set iff lane j holds a real pixel of the current frame; bit K-1 always 1.
- err_ovf_o  out  1  sticky line-overflow flag.

Behaviour:
- Reset (arst_n=0, asynchronous):
  - m_tvalid_o=0, m_tdata_o=0, m_tuser_o=0, m_tlast_o=0, m_row_vld_o=0, err_ovf_o=0.
  - col_q=0, wr_bank_q=0, vcnt_q=0.
  - Line-buffer contents are not reset.
- Handshake:
  - s_tready_o = ~m_tvalid_o | m_tready_i.
  - acc = s_tvalid_i & s_tready_o.
  - Output register loads on acc, so latency is 1 cycle from acceptance to m_tvalid_o.
  - m_tvalid_o clears when m_tready_i=1 and no acc occurs in that cycle.
  - While m_tvalid_o=1 and m_tready_i=0, every output holds stable.
  - Zero-bubble throughput: 1 column/cycle when m_tready_i is held at 1.
- Counters:
  - col_q: column index, width clog2(MAX_W).
  - wr_bank_q: bank pointer, 0..K-2. Bank wr_bank_q holds row r-(K-1).
  - vcnt_q: number of earlier rows valid in the current frame, 0..K-1, saturating.
- Accept of pixel p at column c:
  - Read all K-1 banks at c, then write p into bank wr_bank_q at c in the same cycle (read-before-write).
  - Row r-j is taken from bank (wr_bank_q + K-1-j) mod (K-1), j = 1..K-1.
- Row validity and fill:
  - Lane K-1-j is valid iff j <= vcnt_q (vcnt_q evaluated after any SOF reset, see below).
  - Invalid lanes with BORDER_MODE=0: 0.
  - Invalid lanes with BORDER_MODE=1: copy of the oldest valid lane. On row 0 that is p itself.
  - m_row_vld_o reports validity regardless of mode.
- EOL on acc:
  - col_q=0.
  - wr_bank_q advances, wrapping K-2 -> 0.
  - vcnt_q increments, saturating at K-1.
- SOF on acc:
  - Pixel is treated as row 0, col 0: vcnt_q forced to 0 before lane validity is computed, col_q=0.
  - SOF mid-line or mid-frame restarts the frame the same way; no error is raised.
- SOF and EOL on the same pixel (1-pixel line): the SOF rules apply first, then the EOL update.
- Overflow: on acc with col_q=MAX_W-1 and no EOL:
  - err_ovf_o sets and stays set until reset.
  - col_q holds at MAX_W-1; further pixels overwrite that entry.
- A line shorter than the previous one needs no special handling. A longer line returns stale data for the extra columns while vcnt_q would otherwise mark them valid; this is legal and not flagged.
- Reset mid-frame: all state returns to reset values. The first accepted pixel after reset is treated as row 0 even without SOF.

Test Plan:
- K=3, PIXEL_W=8, MAX_W=4, mode 0; frame of 3 lines x 4 pixels, values 0x10+4r+c, m_tready_i=1 -> row 0 columns {0,0,p}, m_row_vld_o=3'b100; row 2 col 1 = {0x11,0x15,0x19}, m_row_vld_o=3'b111; 1-cycle latency, no bubbles.
- Same frame, mode 1 -> row 0 col 2 = {0x12,0x12,0x12}; row 1 col 0 = {0x10,0x10,0x14}.
- Hold m_tready_i=0 for 3 cycles mid-line -> s_tready_o=0, outputs stable; resume -> no column lost or duplicated (count 12 columns total).
- SOF asserted at row 2 col 2 -> that column has m_row_vld_o=3'b100 and zero-filled lanes; subsequent line sees only 1 prior valid row.
- 5 pixels without EOL into MAX_W=4 -> err_ovf_o=1 after 5th accept, col_q stays 3; deassert arst_n -> err_ovf_o=0, m_tvalid_o=0 immediately (asynchronously).
- K=5, 6 lines of 2 pixels -> wr_bank_q wraps 3->0; row 5 col 0 lanes = rows 1..5 col 0 data.

Source files
------------

// File: rtl/conv_win_cntrl.sv
// Line-buffer controller for a KxK convolution window: keeps K-1 previous lines in
// circular banks and emits one K-tall column per accepted raster pixel.
module conv_win_cntrl #(
  parameter int K           = 5,
  parameter int PIXEL_W     = 8,
  parameter int MAX_W       = 64,
  parameter int BORDER_MODE = 0
) (
  input  logic                 clk,
  input  logic                 arst_n,
  input  logic                 s_tvalid_i,
  input  logic [PIXEL_W-1:0]   s_tdata_i,
  input  logic                 s_tuser_i,
  input  logic                 s_tlast_i,
  output logic                 s_tready_o,
  output logic                 m_tvalid_o,
  input  logic                 m_tready_i,
  output logic [K*PIXEL_W-1:0] m_tdata_o,
  output logic                 m_tuser_o,
  output logic                 m_tlast_o,
  output logic [K-1:0]         m_row_vld_o,
  output logic                 err_ovf_o
);
  localparam int NB = K - 1;
  localparam int CW = (MAX_W > 1) ? $clog2(MAX_W) : 1;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;
  localparam int VW = $clog2(K);

  logic [CW-1:0]      r_col;
  logic [BW-1:0]      r_wr_bank;
  logic [VW-1:0]      r_vcnt;
  logic [PIXEL_W-1:0] r_mem [NB][MAX_W];

  logic                          r_tvalid, r_tuser, r_tlast, r_ovf;
  logic [K-1:0][PIXEL_W-1:0]     r_tdata;
  logic [K-1:0]                  r_row_vld;

  logic                          w_acc;
  logic [CW-1:0]                 w_col_eff, w_col_nxt;
  logic [VW-1:0]                 w_vcnt_eff, w_vcnt_nxt;
  logic [BW-1:0]                 w_bank_nxt;
  logic                          w_col_last;
  logic [K-1:0][PIXEL_W-1:0]     w_raw, w_lane;
  logic [K-1:0]                  w_vld;
  logic [PIXEL_W-1:0]            w_oldest;

  assign s_tready_o = ~r_tvalid | m_tready_i;
  assign w_acc      = s_tvalid_i & s_tready_o;

  // SOF restarts the frame before anything else is evaluated for this pixel
  assign w_col_eff  = s_tuser_i ? '0 : r_col;
  assign w_vcnt_eff = s_tuser_i ? '0 : r_vcnt;
  assign w_col_last = (w_col_eff == CW'(MAX_W - 1));

  always_comb begin
    logic [BW-1:0] v_bank;
    w_raw       = '0;
    w_raw[K-1]  = s_tdata_i;
    v_bank      = '0;
    // row r-j lives in bank (wr_bank + K-1-j) mod (K-1)
    for (int j = 1; j < K; j++) begin
      v_bank         = BW'((int'(r_wr_bank) + NB - j) % NB);
      w_raw[K-1-j]   = r_mem[v_bank][w_col_eff];
    end
    w_oldest = w_raw[VW'(K-1) - w_vcnt_eff];
    w_vld    = '0;
    w_lane   = '0;
    for (int l = 0; l < K; l++) begin
      w_vld[l]  = ((K - 1 - l) <= int'(w_vcnt_eff));
      w_lane[l] = w_vld[l] ? w_raw[l] : ((BORDER_MODE != 0) ? w_oldest : '0);
    end
  end

  always_comb begin
    w_col_nxt  = w_col_eff + 1'b1;
    w_vcnt_nxt = w_vcnt_eff;
    w_bank_nxt = r_wr_bank;
    if (s_tlast_i) begin
      w_col_nxt  = '0;
      w_vcnt_nxt = (w_vcnt_eff == VW'(K - 1)) ? w_vcnt_eff : w_vcnt_eff + 1'b1;
      w_bank_nxt = (r_wr_bank == BW'(NB - 1)) ? '0 : r_wr_bank + 1'b1;
    end else if (w_col_last) begin
      w_col_nxt  = w_col_eff;
    end
  end

  // Banks are plain storage; read above happens before this write lands
  always_ff @(posedge clk) begin
    if (w_acc) r_mem[r_wr_bank][w_col_eff] <= s_tdata_i;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_col     <= '0;
      r_wr_bank <= '0;
      r_vcnt    <= '0;
      r_ovf     <= 1'b0;
      r_tvalid  <= 1'b0;
      r_tdata   <= '0;
      r_tuser   <= 1'b0;
      r_tlast   <= 1'b0;
      r_row_vld <= '0;
    end else begin
      if (w_acc) begin
        r_col     <= w_col_nxt;
        r_wr_bank <= w_bank_nxt;
        r_vcnt    <= w_vcnt_nxt;
        if (!s_tlast_i && w_col_last) r_ovf <= 1'b1;
        r_tvalid  <= 1'b1;
        r_tdata   <= w_lane;
        r_tuser   <= s_tuser_i;
        r_tlast   <= s_tlast_i;
        r_row_vld <= w_vld;
      end else if (m_tready_i) begin
        r_tvalid  <= 1'b0;
      end
    end
  end

  assign m_tvalid_o  = r_tvalid;
  assign m_tdata_o   = r_tdata;
  assign m_tuser_o   = r_tuser;
  assign m_tlast_o   = r_tlast;
  assign m_row_vld_o = r_row_vld;
  assign err_ovf_o   = r_ovf;
endmodule

// File: tb/tb_conv_win_cntrl.sv
// Directed bench: K=3 zero/replicate fill instances plus a K=5 instance share one stream.
module tb_conv_win_cntrl;
  logic       clk = 1'b0;
  logic       arst_n;
  logic       s_tvalid, s_tuser, s_tlast, m_tready;
  logic [7:0] s_tdata;

  logic        rdy0, vld0, usr0, lst0, ovf0;
  logic [23:0] dat0;
  logic [2:0]  rv0;
  logic        rdy1, vld1, usr1, lst1, ovf1;
  logic [23:0] dat1;
  logic [2:0]  rv1;
  logic        rdy2, vld2, usr2, lst2, ovf2;
  logic [39:0] dat2;
  logic [4:0]  rv2;

  int checks = 0;
  int failures = 0;
  int n_cols = 0;

  always #5 clk = ~clk;

  conv_win_cntrl #(.K(3), .PIXEL_W(8), .MAX_W(4), .BORDER_MODE(0)) dut0 (
    .clk(clk), .arst_n(arst_n), .s_tvalid_i(s_tvalid), .s_tdata_i(s_tdata),
    .s_tuser_i(s_tuser), .s_tlast_i(s_tlast), .s_tready_o(rdy0), .m_tvalid_o(vld0),
    .m_tready_i(m_tready), .m_tdata_o(dat0), .m_tuser_o(usr0), .m_tlast_o(lst0),
    .m_row_vld_o(rv0), .err_ovf_o(ovf0));

  conv_win_cntrl #(.K(3), .PIXEL_W(8), .MAX_W(4), .BORDER_MODE(1)) dut1 (
    .clk(clk), .arst_n(arst_n), .s_tvalid_i(s_tvalid), .s_tdata_i(s_tdata),
    .s_tuser_i(s_tuser), .s_tlast_i(s_tlast), .s_tready_o(rdy1), .m_tvalid_o(vld1),
    .m_tready_i(m_tready), .m_tdata_o(dat1), .m_tuser_o(usr1), .m_tlast_o(lst1),
    .m_row_vld_o(rv1), .err_ovf_o(ovf1));

  conv_win_cntrl #(.K(5), .PIXEL_W(8), .MAX_W(4), .BORDER_MODE(0)) dut2 (
    .clk(clk), .arst_n(arst_n), .s_tvalid_i(s_tvalid), .s_tdata_i(s_tdata),
    .s_tuser_i(s_tuser), .s_tlast_i(s_tlast), .s_tready_o(rdy2), .m_tvalid_o(vld2),
    .m_tready_i(m_tready), .m_tdata_o(dat2), .m_tuser_o(usr2), .m_tlast_o(lst2),
    .m_row_vld_o(rv2), .err_ovf_o(ovf2));

  // Columns actually handed downstream by the K=3 zero-fill instance
  always @(posedge clk) if (vld0 && m_tready) n_cols <= n_cols + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one pixel for one edge; caller guarantees s_tready is high
  task automatic push(input logic [7:0] d, input logic sof, input logic eol);
    s_tvalid = 1'b1; s_tdata = d; s_tuser = sof; s_tlast = eol;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    s_tvalid = 1'b0; s_tuser = 1'b0; s_tlast = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    arst_n = 1'b0; s_tvalid = 1'b0; s_tdata = '0; s_tuser = 1'b0; s_tlast = 1'b0;
    m_tready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tvalid", vld0, 0);
    chk("rst_tdata", dat0, 0);
    chk("rst_rowvld", rv0, 0);
    chk("rst_ovf", ovf0, 0);
    chk("rst_tready", rdy0, 1);
    arst_n = 1'b1;
    @(posedge clk); #1;

    // Frame A: 3 lines x 4 pixels, with a 3-cycle downstream stall in row 1
    push(8'h10, 1, 0);
    chk("r0c0_data", dat0, 24'h100000);
    chk("r0c0_vld", rv0, 3'b100);
    chk("r0c0_tuser", usr0, 1);
    chk("r0c0_tvalid", vld0, 1);
    push(8'h11, 0, 0);
    push(8'h12, 0, 0);
    chk("r0c2_rep", dat1, 24'h121212);
    push(8'h13, 0, 1);
    chk("r0c3_tlast", lst0, 1);
    push(8'h14, 0, 0);
    chk("r1c0_zero", dat0, 24'h141000);
    chk("r1c0_vld", rv0, 3'b110);
    chk("r1c0_rep", dat1, 24'h141010);
    push(8'h15, 0, 0);
    chk("r1c1_data", dat0, 24'h151100);
    s_tdata = 8'h16; m_tready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("stall_tready", rdy0, 0);
      chk("stall_hold", dat0, 24'h151100);
      chk("stall_tvalid", vld0, 1);
    end
    m_tready = 1'b1;
    @(posedge clk); #1;
    chk("resume_data", dat0, 24'h161200);
    push(8'h17, 0, 1);
    push(8'h18, 0, 0);
    push(8'h19, 0, 0);
    chk("r2c1_data", dat0, 24'h191511);
    chk("r2c1_vld", rv0, 3'b111);
    chk("r2c1_tlast", lst0, 0);
    push(8'h1A, 0, 0);
    push(8'h1B, 0, 1);
    chk("r2c3_data", dat0, 24'h1B1713);
    idle();
    chk("drain_tvalid", vld0, 0);
    chk("col_count", n_cols, 12);

    // Frame B: SOF arrives at row 2 col 2
    push(8'h20, 1, 0); push(8'h21, 0, 0); push(8'h22, 0, 0); push(8'h23, 0, 1);
    push(8'h24, 0, 0); push(8'h25, 0, 0); push(8'h26, 0, 0); push(8'h27, 0, 1);
    push(8'h28, 0, 0); push(8'h29, 0, 0);
    push(8'h40, 1, 0);
    chk("midsof_data", dat0, 24'h400000);
    chk("midsof_vld", rv0, 3'b100);
    push(8'h41, 0, 0); push(8'h42, 0, 0); push(8'h43, 0, 1);
    push(8'h50, 0, 0);
    chk("aftersof_data", dat0, 24'h504000);
    chk("aftersof_vld", rv0, 3'b110);

    // Overflow: 5 pixels then EOL into MAX_W=4
    push(8'h60, 1, 0); push(8'h61, 0, 0); push(8'h62, 0, 0);
    chk("ovf_before", ovf0, 0);
    push(8'h63, 0, 0); push(8'h64, 0, 0);
    chk("ovf_set", ovf0, 1);
    push(8'h65, 0, 1);
    push(8'h70, 0, 0);
    chk("ovf_c0", dat0, 24'h706000);
    push(8'h71, 0, 0); push(8'h72, 0, 0); push(8'h73, 0, 1);
    chk("ovf_c3_held", dat0, 24'h736500);
    chk("ovf_sticky", ovf0, 1);
    chk("pre_rst_tvalid", vld0, 1);
    #2 arst_n = 1'b0;
    #1;
    chk("async_ovf", ovf0, 0);
    chk("async_tvalid", vld0, 0);
    chk("async_tdata", dat0, 0);
    s_tvalid = 1'b0; s_tuser = 1'b0; s_tlast = 1'b0;
    @(posedge clk); #1;
    arst_n = 1'b1;
    @(posedge clk); #1;

    // K=5: 6 lines of 2 pixels, bank pointer wraps 3 -> 0
    for (int r = 0; r < 6; r++) begin
      for (int c = 0; c < 2; c++) begin
        push(8'(8'h80 + 2 * r + c), (r == 0 && c == 0), (c == 1));
        if (r == 2 && c == 0) begin
          chk("k5_r2c0_data", dat2, 40'h8482800000);
          chk("k5_r2c0_vld", rv2, 5'b11100);
        end
        if (r == 4 && c == 1) chk("k5_r4c1_data", dat2, 40'h8987858381);
        if (r == 5 && c == 0) begin
          chk("k5_r5c0_data", dat2, 40'h8A88868482);
          chk("k5_r5c0_vld", rv2, 5'b11111);
        end
      end
    end
    idle();
    chk("k5_drain", vld2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
